// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I opcode and ALU op constants shared by decode, execute stage and ALU
package riscv_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic [31:0] alu_a;
        logic [31:0] alu_b;
        logic [3:0]  alu_op;
        logic [4:0]  rd;
        logic        rd_we;
        logic [31:0] pc;
        logic        illegal;
    } ex_pkt_t;

endpackage

// File: rtl/id_decode.sv
// id_decode: combinational RV32I ALU-instruction decode into an execute packet
module id_decode
    import riscv_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output ex_pkt_t     pkt
);

    logic [2:0] f3;
    logic [6:0] f7;
    logic       sh;
    logic       legal;

    assign f3 = instr[14:12];
    assign f7 = instr[31:25];
    assign sh = instr[13:12] == 2'b01;

    // funct3 lines up with the low op bits, so op = {funct7[5], funct3} for the register form
    always_comb begin
        pkt = '0;
        pkt.rd = instr[11:7];
        pkt.pc = pc;
        legal = 1'b1;
        case (instr[6:0])
            OPC_OP: begin
                legal = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
                pkt.alu_a = rs1_data;
                pkt.alu_b = rs2_data;
                pkt.alu_op = {f7[5], f3};
            end
            OPC_OP_IMM: begin
                legal = !sh || f7 == 7'h00 || (f3 == 3'b101 && f7 == 7'h20);
                pkt.alu_a = rs1_data;
                pkt.alu_b = sh ? {27'b0, instr[24:20]} : {{20{instr[31]}}, instr[31:20]};
                pkt.alu_op = {f3 == 3'b101 && instr[30], f3};
            end
            OPC_LUI: begin
                pkt.alu_b = {instr[31:12], 12'b0};
                pkt.alu_op = ALU_ADD;
            end
            OPC_AUIPC: begin
                pkt.alu_a = pc;
                pkt.alu_b = {instr[31:12], 12'b0};
                pkt.alu_op = ALU_ADD;
            end
            default: legal = 1'b0;
        endcase
        pkt.alu_a = legal ? pkt.alu_a : 32'b0;
        pkt.alu_b = legal ? pkt.alu_b : 32'b0;
        pkt.alu_op = legal ? pkt.alu_op : ALU_ADD;
        pkt.illegal = !legal;
        pkt.rd_we = legal && pkt.rd != 5'd0;
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with optional two-entry skid buffer
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int SKID_EN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    output logic [4:0]  rd,
    output logic        rd_we,
    output logic [31:0] out_pc,
    output logic        illegal
);

    ex_pkt_t dec;
    ex_pkt_t out_q;
    ex_pkt_t skid_q;
    logic    skid_valid;
    logic    in_fire;
    logic    adv;

    id_decode u_dec (
        .instr    (instr),
        .pc       (pc),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .pkt      (dec)
    );

    assign in_ready = SKID_EN != 0 ? !skid_valid : !out_valid || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign adv      = !out_valid || out_ready;

    // skid entry drains into the output before any new input is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_q      <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (adv) begin
            out_valid  <= skid_valid || in_fire;
            skid_valid <= 1'b0;
            if (skid_valid)
                out_q <= skid_q;
            else if (in_fire)
                out_q <= dec;
        end else if (in_fire && SKID_EN != 0) begin
            skid_valid <= 1'b1;
            skid_q     <= dec;
        end
    end

    assign alu_a   = out_q.alu_a;
    assign alu_b   = out_q.alu_b;
    assign alu_op  = out_q.alu_op;
    assign rd      = out_q.rd;
    assign rd_we   = out_q.rd_we;
    assign out_pc  = out_q.pc;
    assign illegal = out_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vector table plus stall, flush and reset sequences
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] out_pc;
    logic        illegal;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } vec_t;

    vec_t v[15];

    id_ex_stage #(.SKID_EN(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .pc        (pc),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .rd        (rd),
        .rd_we     (rd_we),
        .out_pc    (out_pc),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t e);
        instr = e.instr;
        pc = e.pc;
        rs1_data = e.rs1;
        rs2_data = e.rs2;
    endtask

    task automatic chk_vec(input string tag, input vec_t e);
        chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, " alu_a"}, alu_a, e.a);
        chk({tag, " alu_b"}, alu_b, e.b);
        chk({tag, " alu_op"}, 32'(alu_op), 32'(e.op));
        chk({tag, " rd"}, 32'(rd), 32'(e.rd));
        chk({tag, " rd_we"}, 32'(rd_we), 32'(e.we));
        chk({tag, " illegal"}, 32'(illegal), 32'(e.ill));
        chk({tag, " out_pc"}, out_pc, e.pc);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, " alu_a"}, alu_a, 32'd0);
        chk({tag, " alu_b"}, alu_b, 32'd0);
        chk({tag, " alu_op"}, 32'(alu_op), 32'd0);
        chk({tag, " rd"}, 32'(rd), 32'd0);
        chk({tag, " rd_we"}, 32'(rd_we), 32'd0);
        chk({tag, " illegal"}, 32'(illegal), 32'd0);
        chk({tag, " out_pc"}, out_pc, 32'd0);
    endtask

    initial begin
        //          instr         pc           rs1          rs2         a            b            op     rd  we ill
        v[0]  = '{32'h002081B3, 32'h0000_0010, 32'd5,        32'd7, 32'd5,        32'd7,        4'h0,  5'd3, 1, 0};
        v[1]  = '{32'h40415093, 32'h0000_0014, 32'h80000000, 32'd0, 32'h80000000, 32'd4,        4'hD,  5'd1, 1, 0};
        v[2]  = '{32'hFFF00093, 32'h0000_0018, 32'd0,        32'd0, 32'd0,        32'hFFFFFFFF, 4'h0,  5'd1, 1, 0};
        v[3]  = '{32'h12345297, 32'h0000_0100, 32'd0,        32'd0, 32'h100,      32'h12345000, 4'h0,  5'd5, 1, 0};
        v[4]  = '{32'h00000000, 32'h0000_0104, 32'd5,        32'd7, 32'd0,        32'd0,        4'h0,  5'd0, 0, 1};
        v[5]  = '{32'h00208033, 32'h0000_0108, 32'd5,        32'd7, 32'd5,        32'd7,        4'h0,  5'd0, 0, 0};
        v[6]  = '{32'h40208233, 32'h0000_010C, 32'd9,        32'd3, 32'd9,        32'd3,        4'h8,  5'd4, 1, 0};
        v[7]  = '{32'h4020D333, 32'h0000_0110, 32'h80000000, 32'd4, 32'h80000000, 32'd4,        4'hD,  5'd6, 1, 0};
        v[8]  = '{32'hABCDE3B7, 32'h0000_0114, 32'd5,        32'd7, 32'd0,        32'hABCDE000, 4'h0,  5'd7, 1, 0};
        v[9]  = '{32'h4020C0B3, 32'h0000_0118, 32'd5,        32'd7, 32'd0,        32'd0,        4'h0,  5'd1, 0, 1};
        v[10] = '{32'h40309113, 32'h0000_011C, 32'd5,        32'd7, 32'd0,        32'd0,        4'h0,  5'd2, 0, 1};
        v[11] = '{32'h0F00F193, 32'h0000_0120, 32'h1234,     32'd0, 32'h1234,     32'hF0,       4'h7,  5'd3, 1, 0};
        v[12] = '{32'h01F0D093, 32'h0000_0124, 32'h1234,     32'd0, 32'h1234,     32'd31,       4'h5,  5'd1, 1, 0};
        v[13] = '{32'h0041A133, 32'h0000_0128, 32'd3,        32'd4, 32'd3,        32'd4,        4'h2,  5'd2, 1, 0};
        v[14] = '{32'h000000EF, 32'h0000_012C, 32'd5,        32'd7, 32'd0,        32'd0,        4'h0,  5'd1, 0, 1};

        rst_n = 1'b0;
        in_valid = 1'b1;
        flush = 1'b0;
        out_ready = 1'b1;
        drive(v[0]);
        #3;
        chk_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk_idle("post-reset");

        // back-to-back stream: each vector appears exactly one cycle after it is offered
        for (int i = 0; i <= 15; i++) begin
            if (i > 0) chk_vec($sformatf("vec%0d", i - 1), v[i - 1]);
            if (i < 15) begin
                chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'd1);
                drive(v[i]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("drain out_valid", 32'(out_valid), 32'd0);

        // stall: three back-to-back offers with out_ready low, then release
        out_ready = 1'b0;
        drive(v[0]);
        in_valid = 1'b1;
        @(negedge clk);
        chk_vec("stall A", v[0]);
        chk("stall in_ready c1", 32'(in_ready), 32'd1);
        drive(v[6]);
        @(negedge clk);
        chk("stall in_ready c2", 32'(in_ready), 32'd0);
        chk_vec("stall A hold1", v[0]);
        drive(v[2]);
        @(negedge clk);
        chk("stall in_ready c3", 32'(in_ready), 32'd0);
        chk_vec("stall A hold2", v[0]);
        out_ready = 1'b1;
        @(negedge clk);
        chk_vec("release B", v[6]);
        chk("release in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk_vec("release C", v[2]);
        @(negedge clk);
        chk("release drained", 32'(out_valid), 32'd0);

        // flush with both entries full and a new instruction offered
        out_ready = 1'b0;
        drive(v[3]);
        in_valid = 1'b1;
        @(negedge clk);
        drive(v[7]);
        @(negedge clk);
        chk("flush pre in_ready", 32'(in_ready), 32'd0);
        drive(v[8]);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("flush out_valid", 32'(out_valid), 32'd0);
        chk("flush in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("flush quiet%0d", i), 32'(out_valid), 32'd0);
        end

        // reset in the middle of a full stall, then accept on the first edge after release
        out_ready = 1'b0;
        drive(v[11]);
        in_valid = 1'b1;
        @(negedge clk);
        drive(v[12]);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_idle("midstall reset");
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive(v[13]);
        @(negedge clk);
        in_valid = 1'b0;
        chk_vec("after reset", v[13]);
        @(negedge clk);
        chk("after reset drained", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter SKID_EN, default 1, meaning 1 = two-entry skid buffer, 0 = single register with in_ready = !out_valid || out_ready.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  decode-side instruction valid.
REQ-005 SHALL have port in_ready  output  1  stage can accept an instruction.
REQ-006 SHALL have port instr  input  32  RV32I instruction word.
REQ-007 SHALL have port pc  input  32  instruction address.
REQ-008 SHALL have ports rs1_data, rs2_data  input  32 each  register-file read data.
REQ-009 SHALL have port flush  input  1  synchronous pipeline kill.
REQ-010 SHALL have port out_valid  output  1  ALU operands valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts.
REQ-012 SHALL have ports alu_a, alu_b  output  32 each  ALU operands.
REQ-013 SHALL have port alu_op  output  4  ALU operation code.
REQ-014 SHALL have ports rd  output  5, rd_we  output  1, out_pc  output  32, illegal  output  1.

Function
REQ-015 SHALL transfer on input when in_valid && in_ready, on output when out_valid && out_ready.
REQ-016 SHALL present a transferred instruction on outputs the next cycle (latency 1), throughput 1/cycle with out_ready held high.
REQ-017 SHALL hold all outputs stable while out_valid && !out_ready.
REQ-018 SHALL, with SKID_EN=1, drive in_ready from a register: in_ready = !skid_valid; an input accepted while output stalls goes to the skid entry, which moves to the output on the next output transfer.
REQ-019 SHALL encode alu_op: ADD 0000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, OR 0110, AND 0111, SUB 1000, SRA 1101.
REQ-020 SHALL decode OP (0110011): a=rs1, b=rs2; funct7[5]=1 selects SUB (funct3 000) or SRA (funct3 101).
REQ-021 SHALL decode OP-IMM (0010011): a=rs1, b=sign-extended instr[31:20]; shifts use b = zero-extended instr[24:20], instr[30] selects SRA.
REQ-022 SHALL decode LUI: a=0, b={instr[31:12],12'b0}, op ADD; AUIPC: a=pc, same b, op ADD.
REQ-023 SHALL treat any other opcode, or a bad funct7 on OP/shift-immediate, as illegal: illegal=1, rd_we=0, op ADD, a=b=0.
REQ-024 SHALL force rd_we=0 when rd=0.
REQ-025 SHALL, on flush, clear out_valid and skid_valid at the next edge, discard any instruction offered that cycle, and set in_ready=1 next cycle.
REQ-026 SHALL give flush priority over simultaneous input and output transfers.

Reset
REQ-027 SHALL on rst_n low immediately set out_valid=0, skid_valid=0, in_ready=1, alu_a=alu_b=out_pc=0, alu_op=0000, rd=0, rd_we=0, illegal=0.
REQ-028 SHALL, on reset mid-stall, drop both buffered entries and accept input on the first edge after release.

Structure
REQ-029 SHALL take ALU op constants and RV32I opcode constants from the shared package riscv_pkg, which the ALU also uses.
REQ-030 SHALL place combinational decode in sub-module id_decode; id_ex_stage holds only the buffer/handshake logic.

Verification
REQ-031 SHALL test: add x3,x1,x2 with rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, alu_op=0000, a=5, b=7, rd=3, rd_we=1.
REQ-032 SHALL test: srai x1,x2,4 (instr 0x40415093), rs1=0x80000000 -> alu_op=1101, b=4; addi x1,x0,-1 -> b=0xFFFFFFFF.
REQ-033 SHALL test: auipc x5,0x12345 at pc=0x100 -> a=0x100, b=0x12345000, op 0000.
REQ-034 SHALL test: out_ready=0 with 3 back-to-back inputs -> 2 accepted, in_ready=0 on cycle 2, outputs stable; release -> in order, no loss.
REQ-035 SHALL test: flush with both entries full and in_valid=1 -> out_valid=0 next cycle, in_ready=1, offered instruction never appears.
REQ-036 SHALL test: instr 0x00000000 -> illegal=1, rd_we=0; add x0,x1,x2 -> rd_we=0.
